// File: rtl/regfile_loader.sv
// Byte-stream register-file preloader: stalls the processor, then turns
// {address, 4 data bytes} records into regfile write-port pulses.
module regfile_loader #(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [7:0]  END_BYTE     = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        proc_hold,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [5:0]  wr_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_QUIESCE = 3'd1;
    localparam logic [2:0] S_ADDR    = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    // A zero drain length still spends one cycle in QUIESCE.
    localparam int DRAIN_LOAD = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0;
    localparam int CNT_W      = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    logic [2:0]       state;
    logic [CNT_W-1:0] drain_cnt;
    logic [1:0]       byte_idx;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others; blocking here would create ordering races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            byte_idx  <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            err       <= 1'b0;
            wr_count  <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        err       <= 1'b0;
                        wr_count  <= '0;
                        drain_cnt <= CNT_W'(DRAIN_LOAD);
                        state     <= S_QUIESCE;
                    end
                end
                S_QUIESCE: begin
                    if (drain_cnt == '0) state <= S_ADDR;
                    else                 drain_cnt <= drain_cnt - CNT_W'(1);
                end
                S_ADDR: begin
                    if (in_valid) begin
                        if (in_data < 8'd32) begin
                            rf_waddr <= in_data[4:0];
                            byte_idx <= '0;
                            state    <= S_DATA;
                        end else if (in_data == END_BYTE) begin
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        rf_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // r0 is hardwired, so writes to it are neither issued nor counted.
                    if (rf_waddr != 5'd0 && wr_count != 6'd63)
                        wr_count <= wr_count + 6'd1;
                    state <= S_ADDR;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        in_ready  = 1'b0;
        proc_hold = 1'b0;
        rf_we     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_QUIESCE: begin
                proc_hold = 1'b1;
                busy      = 1'b1;
            end
            S_ADDR, S_DATA: begin
                in_ready  = 1'b1;
                proc_hold = 1'b1;
                busy      = 1'b1;
            end
            S_WRITE: begin
                proc_hold = 1'b1;
                busy      = 1'b1;
                rf_we     = (rf_waddr != 5'd0);
            end
            S_DONE: begin
                proc_hold = 1'b1;
                busy      = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_loader.sv
// Scoreboard bench for regfile_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares them whenever rf_we is seen.
module tb_regfile_loader;

    localparam int         DRAIN    = 4;
    localparam logic [7:0] END_BYTE = 8'hFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, proc_hold, rf_we, busy, done, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  wr_count;

    regfile_loader #(.DRAIN_CYCLES(DRAIN), .END_BYTE(END_BYTE)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .proc_hold (proc_hold),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_count  (wr_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model state: pending writes, expected write count and done pulses.
    logic [36:0] exp_q[$];
    int          exp_wr   = 0;
    int          exp_done = 0;
    int          done_cnt = 0;
    logic        prev_we  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each observed write against the scoreboard queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (rf_we) begin
                check("we_one_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
                    check("write_data", rf_wdata, e[31:0]);
                end
            end
            if (done) done_cnt++;
        end
        prev_we = rf_we;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  0);
        check({tag, "_proc_hold"}, {31'd0, proc_hold}, 0);
        check({tag, "_rf_we"},     {31'd0, rf_we},     0);
        check({tag, "_busy"},      {31'd0, busy},      0);
        check({tag, "_done"},      {31'd0, done},      0);
        check({tag, "_err"},       {31'd0, err},       0);
        check({tag, "_wr_count"},  {26'd0, wr_count},  0);
    endtask

    task automatic do_start();
        int k;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        exp_wr = 0;
        check("start_hold",     {31'd0, proc_hold}, 1);
        check("start_err_clr",  {31'd0, err},       0);
        check("start_wr_clr",   {26'd0, wr_count},  0);
        check("start_not_rdy",  {31'd0, in_ready},  0);
        k = 0;
        while (k < 50) begin
            @(posedge clock);
            #1;
            k++;
            if (in_ready) break;
        end
        check("ready_latency", k, DRAIN);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        @(posedge clock);
    endtask

    task automatic send_record(input logic [4:0] addr, input logic [31:0] data, input int max_gap);
        logic [7:0] abyte;
        abyte = {3'b000, addr};
        if (addr != 5'd0) begin
            exp_q.push_back({addr, data});
            exp_wr = (exp_wr >= 63) ? 63 : exp_wr + 1;
        end
        send_byte(abyte, $urandom_range(0, max_gap));
        for (int k = 0; k < 4; k++)
            send_byte(data[8*k +: 8], $urandom_range(0, max_gap));
    endtask

    task automatic finish_load(input string tag);
        int n;
        send_byte(END_BYTE, 0);
        exp_done++;
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 1);
        @(negedge clock);
        check({tag, "_done_once"},  {31'd0, done},      0);
        check({tag, "_hold_low"},   {31'd0, proc_hold}, 0);
        check({tag, "_busy_low"},   {31'd0, busy},      0);
        check({tag, "_wr_count"},   {26'd0, wr_count},  exp_wr);
        check({tag, "_done_count"}, done_cnt,           exp_done);
        check({tag, "_all_writes"}, exp_q.size(),       0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Single record to r1.
        do_start();
        send_record(5'd1, 32'h1234_5678, 0);
        finish_load("basic");

        // r0 must not be written; r31 must.
        do_start();
        send_record(5'd0,  32'hDEAD_BEEF, 0);
        send_record(5'd31, 32'h0000_0001, 0);
        finish_load("r0_r31");

        // Random in_valid gaps over three records.
        do_start();
        for (int i = 0; i < 3; i++)
            send_record(5'($urandom_range(1, 31)), $urandom, 3);
        finish_load("gaps");

        // Bad address after one good record.
        do_start();
        send_record(5'd9, $urandom, 1);
        send_byte(8'h40, 0);
        @(negedge clock);
        in_valid = 1'b0;
        check("err_set",      {31'd0, err},       1);
        check("err_hold",     {31'd0, proc_hold}, 0);
        check("err_busy",     {31'd0, busy},      0);
        check("err_ready",    {31'd0, in_ready},  0);
        check("err_wr_count", {26'd0, wr_count},  1);
        do_start();
        send_record(5'd12, $urandom, 1);
        finish_load("after_err");

        // Reset in the middle of the data bytes.
        do_start();
        send_byte(8'h05, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset = 1'b0;
        do_start();
        send_record(5'd5, $urandom, 2);
        finish_load("after_reset");

        // start during ADDR and during WRITE is ignored.
        do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_in_addr_ready", {31'd0, in_ready},  1);
        check("start_in_addr_hold",  {31'd0, proc_hold}, 1);
        send_record(5'd7, 32'hCAFE_F00D, 0);
        @(negedge clock);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_in_write_ready", {31'd0, in_ready}, 1);
        check("start_in_write_count", {26'd0, wr_count}, 1);
        finish_load("start_ignored");

        // Random load including r0 and repeated addresses.
        do_start();
        for (int i = 0; i < 8; i++)
            send_record(5'($urandom_range(0, 7)), $urandom, 2);
        finish_load("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
